// File: rtl/boot_rom_pkg.sv
// Shared constants for the patchable boot ROM.
// Widths of the patch entry depend on module parameters, so the entry struct
// itself is declared inside boot_rom_patch_table from its localparams.
//   MAX_PATCH  : upper bound on the number of patch entries
//   RESP_OK/ERR: encoding of r_opc_o
//   idx_width(): width of a patch index, never less than one bit
package boot_rom_pkg;

    localparam int   MAX_PATCH = 16;
    localparam logic RESP_OK   = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/boot_rom_patch_table.sv
// Patch table for the boot ROM: N_PATCH entries of {en, word address, data},
// a sticky lock flag, and a priority match against the current lookup address.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   we, idx      : write strobe and entry index (out-of-range index ignored)
//   waddr, wdata : word address to patch and replacement word
//   en           : enable bit written into the entry
//   lock         : sets locked; stays set until reset
//   bypass       : suppresses every match
//   lookup_addr  : word address of the current request
//   locked       : table is write-protected
//   hit, hit_data: lowest-index enabled entry matching lookup_addr, and its data
module boot_rom_patch_table import boot_rom_pkg::*; #(
    parameter  int N_PATCH    = 4,
    parameter  int ADDR_WIDTH = 11,
    parameter  int DATA_WIDTH = 32,
    localparam int IDX_WIDTH  = idx_width(N_PATCH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  idx,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  en,
    input  logic                  lock,
    input  logic                  bypass,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic                  locked,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] hit_data
);

    typedef struct packed {
        logic                  en;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } patch_entry_t;

    patch_entry_t entries [N_PATCH];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PATCH; i++) begin
                entries[i] <= '0;
            end
            locked <= 1'b0;
        end else begin
            // The write is qualified by the lock flag as it was before this
            // edge, so a write issued together with the lock pulse still lands.
            if (we && !locked && (32'(idx) < N_PATCH)) begin
                entries[idx] <= '{en: en, addr: waddr, data: wdata};
            end
            if (lock) begin
                locked <= 1'b1;
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        // Scan from the highest index down: the lowest matching index is
        // the last one to assign and therefore wins.
        for (int i = N_PATCH - 1; i >= 0; i--) begin
            if (!bypass && entries[i].en && (entries[i].addr == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = entries[i].data;
            end
        end
    end

endmodule

// File: rtl/generic_rom.sv
// Behavioural stand-in for the boot ROM hard macro (active-low chip enable,
// one-cycle registered read). Its contents are a fixed pattern:
// word i holds INIT_BASE + i.
// Ports:
//   CLK : clock
//   CEN : chip enable, active low
//   A   : word address
//   Q   : read data, valid the cycle after an enabled access, held otherwise
module generic_rom #(
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_BASE  = 'hB000_0000
) (
    input  logic                  CLK,
    input  logic                  CEN,
    input  logic [ADDR_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] Q
);

    // NOTE: a memory output register has no reset; whoever consumes Q masks it
    // with its own valid flag, so resetting the array wastes area and routing.
    always_ff @(posedge CLK) begin
        if (!CEN) begin
            Q <= INIT_BASE + DATA_WIDTH'(A);
        end
    end

endmodule

// File: rtl/boot_rom_patch.sv
// Patchable boot ROM on the SoC interconnect (TCDM-style slave at BASE_ADDR).
// In-range reads are served from the ROM macro, or from the patch table when
// an enabled entry matches the word; writes and out-of-range reads return an
// error response. Every request gets exactly one response READ_LATENCY cycles
// later; there is no back-pressure.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   test_mode_i          : bypass all patches
//   req_i/add_i/wen_i    : request, byte address, 1 = read / 0 = write
//   gnt_o                : grant (always equals req_i)
//   r_valid_o/r_rdata_o/r_opc_o : response valid, data, error flag
//                          (data and flag are zero while r_valid_o is low)
//   cfg_we_i/cfg_idx_i/cfg_waddr_i/cfg_wdata_i/cfg_en_i : patch entry write
//   cfg_lock_i           : lock pulse
//   locked_o             : patch table locked
module boot_rom_patch import boot_rom_pkg::*; #(
    parameter  int          ROM_ADDR_WIDTH = 13,
    parameter  int          DATA_WIDTH     = 32,
    parameter  int          N_PATCH        = 4,
    parameter  int          READ_LATENCY   = 1,
    parameter  logic [31:0] BASE_ADDR      = 32'h1A00_0000,
    localparam int          WORD_AW        = ROM_ADDR_WIDTH - 2,
    localparam int          IDX_WIDTH      = idx_width(N_PATCH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_mode_i,
    input  logic                  req_i,
    input  logic [31:0]           add_i,
    input  logic                  wen_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic [DATA_WIDTH-1:0] r_rdata_o,
    output logic                  r_opc_o,
    input  logic                  cfg_we_i,
    input  logic [IDX_WIDTH-1:0]  cfg_idx_i,
    input  logic [WORD_AW-1:0]    cfg_waddr_i,
    input  logic [DATA_WIDTH-1:0] cfg_wdata_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_lock_i,
    output logic                  locked_o
);

    localparam int STAGE = READ_LATENCY - 1;

    if (N_PATCH < 1 || N_PATCH > MAX_PATCH) begin : g_bad_n_patch
        $error("boot_rom_patch: N_PATCH must be in 1..16");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
        $error("boot_rom_patch: READ_LATENCY must be 1 or 2");
    end

    // ---------------- address decode ----------------
    logic [31:0]         off;
    logic                in_range;
    logic [WORD_AW-1:0]  word_idx;
    logic                rd_ok;
    logic                resp_err;

    // Wrap-around subtraction: addresses below BASE_ADDR become huge offsets
    // and fail the range test.
    assign off      = add_i - BASE_ADDR;
    assign in_range = (off >> ROM_ADDR_WIDTH) == 32'd0;
    assign word_idx = off[ROM_ADDR_WIDTH-1:2];
    assign rd_ok    = req_i & wen_i & in_range;
    assign resp_err = req_i & ~rd_ok;
    assign gnt_o    = req_i;

    // ---------------- patch table ----------------
    logic                  patch_hit;
    logic [DATA_WIDTH-1:0] patch_data;

    boot_rom_patch_table #(
        .N_PATCH    (N_PATCH),
        .ADDR_WIDTH (WORD_AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) i_table (
        .clk         (clk_i),
        .rst_n       (rst_ni),
        .we          (cfg_we_i),
        .idx         (cfg_idx_i),
        .waddr       (cfg_waddr_i),
        .wdata       (cfg_wdata_i),
        .en          (cfg_en_i),
        .lock        (cfg_lock_i),
        .bypass      (test_mode_i),
        .lookup_addr (word_idx),
        .locked      (locked_o),
        .hit         (patch_hit),
        .hit_data    (patch_data)
    );

    // ---------------- ROM macro ----------------
    logic                  rom_cen;
    logic [DATA_WIDTH-1:0] rom_q;
    logic [DATA_WIDTH-1:0] rom_word;

    // Only in-range reads touch the macro; errors leave it idle.
    assign rom_cen = ~rd_ok;

`ifdef PULP_FPGA_EMUL
    fpga_bootrom #(
        .ADDR_WIDTH (WORD_AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) i_rom (
        .CLK (clk_i),
        .CEN (rom_cen),
        .A   (word_idx),
        .Q   (rom_q)
    );
`else
    generic_rom #(
        .ADDR_WIDTH (WORD_AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) i_rom (
        .CLK (clk_i),
        .CEN (rom_cen),
        .A   (word_idx),
        .Q   (rom_q)
    );
`endif

    // ---------------- response pipeline ----------------
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY-1:0] pipe_err;
    logic [READ_LATENCY-1:0] pipe_hit;
    logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];

    // Reset empties the pipeline, so requests in flight at reset never respond.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            pipe_hit   <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= req_i;
            pipe_err[0]   <= resp_err;
            pipe_hit[0]   <= rd_ok & patch_hit;
            pipe_data[0]  <= patch_data;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_hit[i]   <= pipe_hit[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    // With two cycles of latency the macro output is re-registered so it
    // lines up with the last pipeline stage.
    if (READ_LATENCY == 2) begin : g_rom_reg
        logic [DATA_WIDTH-1:0] rom_q_r;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rom_q_r <= '0;
            end else if (pipe_valid[0]) begin
                rom_q_r <= rom_q;
            end
        end
        assign rom_word = rom_q_r;
    end else begin : g_rom_direct
        assign rom_word = rom_q;
    end

    // ---------------- response outputs ----------------
    assign r_valid_o = pipe_valid[STAGE];
    assign r_opc_o   = (pipe_valid[STAGE] && pipe_err[STAGE]) ? RESP_ERR : RESP_OK;

    always_comb begin
        r_rdata_o = '0;
        if (pipe_valid[STAGE] && !pipe_err[STAGE]) begin
            r_rdata_o = pipe_hit[STAGE] ? pipe_data[STAGE] : rom_word;
        end
    end

endmodule

// File: tb/tb_boot_rom_patch.sv
// Self-checking bench for boot_rom_patch. Two instances (READ_LATENCY 1 and 2)
// share one stimulus stream; each has its own scoreboard queue of expected
// responses tagged with the cycle they are due in. A negedge monitor compares
// every cycle: due responses, idle masking, grant and lock state.
`timescale 1ns/1ps
module tb_boot_rom_patch;

    localparam int          AW   = 13;
    localparam int          WAW  = AW - 2;
    localparam int          NP   = 4;
    localparam logic [31:0] BASE = 32'h1A00_0000;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           test_mode = 1'b0;
    logic           req       = 1'b0;
    logic [31:0]    add       = '0;
    logic           wen       = 1'b1;
    logic           cfg_we    = 1'b0;
    logic [1:0]     cfg_idx   = '0;
    logic [WAW-1:0] cfg_waddr = '0;
    logic [31:0]    cfg_wdata = '0;
    logic           cfg_en    = 1'b0;
    logic           cfg_lock  = 1'b0;

    logic        gnt1, valid1, opc1, locked1;
    logic [31:0] rdata1;
    logic        gnt2, valid2, opc2, locked2;
    logic [31:0] rdata2;

    always #5 clk = ~clk;

    boot_rom_patch #(.READ_LATENCY(1)) u_lat1 (
        .clk_i(clk), .rst_ni(rst_n), .test_mode_i(test_mode),
        .req_i(req), .add_i(add), .wen_i(wen), .gnt_o(gnt1),
        .r_valid_o(valid1), .r_rdata_o(rdata1), .r_opc_o(opc1),
        .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_waddr_i(cfg_waddr),
        .cfg_wdata_i(cfg_wdata), .cfg_en_i(cfg_en), .cfg_lock_i(cfg_lock),
        .locked_o(locked1)
    );

    boot_rom_patch #(.READ_LATENCY(2)) u_lat2 (
        .clk_i(clk), .rst_ni(rst_n), .test_mode_i(test_mode),
        .req_i(req), .add_i(add), .wen_i(wen), .gnt_o(gnt2),
        .r_valid_o(valid2), .r_rdata_o(rdata2), .r_opc_o(opc2),
        .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_waddr_i(cfg_waddr),
        .cfg_wdata_i(cfg_wdata), .cfg_en_i(cfg_en), .cfg_lock_i(cfg_lock),
        .locked_o(locked2)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        opc;
    } exp_t;

    typedef struct {
        logic [31:0] add;
        logic        rd;
        logic [31:0] data;
        logic        opc;
    } vec_t;

    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    // Reference patch table
    logic           m_en     [NP];
    logic [WAW-1:0] m_addr   [NP];
    logic [31:0]    m_data   [NP];
    logic           m_locked;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic mon_dut(input int lat, input logic v, input logic [31:0] d,
                           input logic o, input logic g, input logic lk);
        exp_t e;
        bit   due;
        due = 1'b0;
        if (lat == 1) begin
            if (q1.size() > 0 && q1[0].due <= cyc) begin e = q1.pop_front(); due = 1'b1; end
        end else begin
            if (q2.size() > 0 && q2[0].due <= cyc) begin e = q2.pop_front(); due = 1'b1; end
        end
        if (due) begin
            check($sformatf("lat%0d resp cycle", lat), 32'(e.due), 32'(cyc));
            check($sformatf("lat%0d r_valid", lat), 32'(v), 32'd1);
            check($sformatf("lat%0d r_rdata", lat), d, e.data);
            check($sformatf("lat%0d r_opc", lat), 32'(o), 32'(e.opc));
        end else begin
            check($sformatf("lat%0d idle r_valid", lat), 32'(v), 32'd0);
            check($sformatf("lat%0d idle r_rdata", lat), d, 32'd0);
            check($sformatf("lat%0d idle r_opc", lat), 32'(o), 32'd0);
        end
        check($sformatf("lat%0d gnt", lat), 32'(g), 32'(req));
        check($sformatf("lat%0d locked", lat), 32'(lk), 32'(m_locked));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_dut(1, valid1, rdata1, opc1, gnt1, locked1);
            mon_dut(2, valid2, rdata2, opc2, gnt2, locked2);
        end
    end

    task automatic clear_model();
        for (int i = 0; i < NP; i++) begin
            m_en[i]   = 1'b0;
            m_addr[i] = '0;
            m_data[i] = '0;
        end
        m_locked = 1'b0;
    endtask

    // One clock: the model absorbs the config inputs seen at the edge (write
    // first, then lock), then single-cycle strobes return to idle.
    task automatic tick();
        @(posedge clk);
        if (cfg_we && !m_locked && (int'(cfg_idx) < NP)) begin
            m_en[cfg_idx]   = cfg_en;
            m_addr[cfg_idx] = cfg_waddr;
            m_data[cfg_idx] = cfg_wdata;
        end
        if (cfg_lock) m_locked = 1'b1;
        #1;
        req      = 1'b0;
        wen      = 1'b1;
        cfg_we   = 1'b0;
        cfg_lock = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic rd,
                         input logic [31:0] ed, input logic eo);
        exp_t e;
        req    = 1'b1;
        wen    = rd;
        add    = a;
        e.data = ed;
        e.opc  = eo;
        e.due  = cyc + 1;
        q1.push_back(e);
        e.due  = cyc + 2;
        q2.push_back(e);
        tick();
    endtask

    // Expected read result from the reference model (ROM word i = B000_0000+i).
    task automatic issue_model(input logic [31:0] a, input logic rd);
        logic [31:0]    off;
        logic [WAW-1:0] w;
        logic [31:0]    d;
        logic           hit;
        off = a - BASE;
        w   = off[AW-1:2];
        if (!rd || (off >> AW) != 0) begin
            issue(a, rd, 32'd0, 1'b1);
        end else begin
            d   = 32'hB000_0000 + 32'(w);
            hit = 1'b0;
            for (int i = 0; i < NP; i++) begin
                if (!hit && !test_mode && m_en[i] && m_addr[i] == w) begin
                    d   = m_data[i];
                    hit = 1'b1;
                end
            end
            issue(a, rd, d, 1'b0);
        end
    endtask

    task automatic cfg_set(input int idx, input logic en, input int waddr,
                           input logic [31:0] data, input logic lock);
        cfg_we    = 1'b1;
        cfg_idx   = 2'(idx);
        cfg_en    = en;
        cfg_waddr = WAW'(waddr);
        cfg_wdata = data;
        cfg_lock  = lock;
    endtask

    task automatic cfg_write(input int idx, input logic en, input int waddr,
                             input logic [31:0] data, input logic lock);
        cfg_set(idx, en, waddr, data, lock);
        tick();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        q1.delete();
        q2.delete();
        clear_model();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [9];
        vecs[0] = '{32'h1A00_0010, 1'b1, 32'hB000_0004, 1'b0};  // word 4
        vecs[1] = '{32'h1A00_0000, 1'b1, 32'hB000_0000, 1'b0};  // first word
        vecs[2] = '{32'h1A00_0013, 1'b1, 32'hB000_0004, 1'b0};  // byte bits ignored
        vecs[3] = '{32'h1A00_1FFC, 1'b1, 32'hB000_07FF, 1'b0};  // last word
        vecs[4] = '{32'h1A00_2000, 1'b1, 32'h0000_0000, 1'b1};  // one past the end
        vecs[5] = '{32'h19FF_FFFC, 1'b1, 32'h0000_0000, 1'b1};  // below base, wraps
        vecs[6] = '{32'h1A00_0000, 1'b0, 32'h0000_0000, 1'b1};  // write
        vecs[7] = '{32'h1A00_0010, 1'b0, 32'h0000_0000, 1'b1};  // write
        vecs[8] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};  // far away

        clear_model();
        @(posedge clk);
        #1 mon_en = 1'b1;             // reset values are checked while rst_n is low
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Isolated requests: one response each, exactly READ_LATENCY later.
        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].add, vecs[i].rd, vecs[i].data, vecs[i].opc);
            tick();
            tick();
        end

        // Back-to-back reads of words 0..7.
        for (int i = 0; i < 8; i++) begin
            issue_model(BASE + 32'(4 * i), 1'b1);
        end
        repeat (3) tick();

        // Patching and priority.
        cfg_write(2, 1'b1, 4, 32'hDEAD_BEEF, 1'b0);
        issue(BASE + 32'h10, 1'b1, 32'hDEAD_BEEF, 1'b0);
        cfg_write(1, 1'b1, 4, 32'h1234_5678, 1'b0);
        issue(BASE + 32'h10, 1'b1, 32'h1234_5678, 1'b0);
        test_mode = 1'b1;
        issue(BASE + 32'h10, 1'b1, 32'hB000_0004, 1'b0);
        test_mode = 1'b0;
        issue(BASE + 32'h10, 1'b1, 32'h1234_5678, 1'b0);

        // A write and a read of the same word in one cycle: read sees the old table.
        cfg_set(0, 1'b1, 5, 32'h5555_5555, 1'b0);
        issue(BASE + 32'h14, 1'b1, 32'hB000_0005, 1'b0);
        issue(BASE + 32'h14, 1'b1, 32'h5555_5555, 1'b0);

        // Disabling entry 1 exposes entry 2.
        cfg_write(1, 1'b0, 4, 32'h0, 1'b0);
        issue(BASE + 32'h10, 1'b1, 32'hDEAD_BEEF, 1'b0);

        // Write together with the lock pulse lands; later writes are ignored.
        cfg_write(3, 1'b1, 7, 32'hCAFE_0007, 1'b1);
        issue(BASE + 32'h1C, 1'b1, 32'hCAFE_0007, 1'b0);
        cfg_write(0, 1'b1, 0, 32'hFFFF_FFFF, 1'b0);
        issue(BASE + 32'h00, 1'b1, 32'hB000_0000, 1'b0);
        issue(BASE + 32'h14, 1'b1, 32'h5555_5555, 1'b0);
        cfg_write(0, 1'b0, 0, 32'h0, 1'b1);
        issue_model(BASE + 32'h10, 1'b1);
        repeat (3) tick();

        // Reset with requests in flight: no response ever appears.
        issue(BASE + 32'h10, 1'b1, 32'hDEAD_BEEF, 1'b0);
        apply_reset();
        repeat (4) tick();

        // Table and lock cleared by reset; writes accepted again.
        issue(BASE + 32'h10, 1'b1, 32'hB000_0004, 1'b0);
        issue(BASE + 32'h1C, 1'b1, 32'hB000_0007, 1'b0);
        cfg_write(0, 1'b1, 1, 32'hABCD_0001, 1'b0);
        issue(BASE + 32'h04, 1'b1, 32'hABCD_0001, 1'b0);
        repeat (4) tick();

        check("lat1 scoreboard drained", 32'(q1.size()), 32'd0);
        check("lat2 scoreboard drained", 32'(q2.size()), 32'd0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
